resp_tx_fifo: RTL and testbench

RESP_TX_FIFO -- requirements
Module: resp_tx_fifo

---
 rtl/resp_tx_fifo.sv | 130 +++++++++++++
 tb/tb_resp_tx_fifo.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/resp_tx_fifo.sv
// Queues 16-bit read responses and sends each one to a UART as the ASCII frame 'M' + 4 hex digits + terminator.
// Define RESP_TX_CRLF_EN to end frames with CR LF. Without it, frames end with LF only.
module resp_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] rdata_i,
    input  logic        rw_i,
    input  logic        valid_i,
    input  logic        ready_i,
    output logic [7:0]  data_o,
    output logic        valid_o,
    output logic        overflow_o
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, HDR, N3, N2, N1, N0, CR, LF} state_t;

    state_t        state_q;
    logic [15:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q, count_d;
    logic [15:0]   frame_q;
    logic [7:0]    data_q;
    logic          valid_q, ovf_q;
    logic          empty, full, accept, pop, push_req, push;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign empty    = (count_q == '0);
    assign full     = (count_q == (PW+1)'(DEPTH));
    assign accept   = valid_q && ready_i;
    // Pops happen from IDLE, or back-to-back as the LF byte is taken.
    assign pop      = !empty && ((state_q == IDLE) || (state_q == LF && accept));
    assign push_req = valid_i && !rw_i;
    assign push     = push_req && (!full || pop);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rdata_i;
        if (pop)  frame_q <= mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            ovf_q   <= push_req && !push;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (pop) begin
                    state_q <= HDR;
                    data_q  <= 8'h4D;
                    valid_q <= 1'b1;
                end
                HDR: if (accept) begin
                    state_q <= N3;
                    data_q  <= hex_ascii(frame_q[15:12]);
                end
                N3: if (accept) begin
                    state_q <= N2;
                    data_q  <= hex_ascii(frame_q[11:8]);
                end
                N2: if (accept) begin
                    state_q <= N1;
                    data_q  <= hex_ascii(frame_q[7:4]);
                end
                N1: if (accept) begin
                    state_q <= N0;
                    data_q  <= hex_ascii(frame_q[3:0]);
                end
                N0: if (accept) begin
`ifdef RESP_TX_CRLF_EN
                    state_q <= CR;
                    data_q  <= 8'h0D;
`else
                    state_q <= LF;
                    data_q  <= 8'h0A;
`endif
                end
                CR: if (accept) begin
                    state_q <= LF;
                    data_q  <= 8'h0A;
                end
                LF: if (accept) begin
                    if (pop) begin
                        state_q <= HDR;
                        data_q  <= 8'h4D;
                    end else begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign overflow_o = ovf_q;
endmodule

// File: tb/tb_resp_tx_fifo.sv
// Directed bench for resp_tx_fifo: framing, stalls, overflow, reset abandonment and back-to-back frames.
module tb_resp_tx_fifo;
    localparam int DEPTH = 4;
`ifdef RESP_TX_CRLF_EN
    localparam int FLEN = 7;
`else
    localparam int FLEN = 6;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] rdata_i;
    logic        rw_i, valid_i, ready_i;
    logic [7:0]  data_o;
    logic        valid_o, overflow_o;

    int errors = 0;
    int checks = 0;
    int ovf_cnt = 0;
    logic [7:0] q[$];

    resp_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rdata_i(rdata_i), .rw_i(rw_i), .valid_i(valid_i),
        .ready_i(ready_i), .data_o(data_o), .valid_o(valid_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    // Byte accepted at the next rising edge is visible here at the falling edge.
    always @(negedge clk) begin
        if (valid_o && ready_i) q.push_back(data_o);
        if (overflow_o) ovf_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_read(input logic [15:0] d);
        rdata_i = d;
        rw_i    = 1'b0;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] h3, input logic [7:0] h2,
                                input logic [7:0] h1, input logic [7:0] h0);
        logic [7:0] exp[$];
        int n;
        exp = {8'h4D, h3, h2, h1, h0};
`ifdef RESP_TX_CRLF_EN
        exp.push_back(8'h0D);
`endif
        exp.push_back(8'h0A);
        n = 0;
        while (q.size() < FLEN && n < 200) begin
            tick();
            n++;
        end
        if (q.size() < FLEN) begin
            chk({tag, "_timeout"}, 16'(q.size()), 16'(FLEN));
        end else begin
            for (int i = 0; i < FLEN; i++) chk($sformatf("%s_b%0d", tag, i), {8'h00, q.pop_front()}, {8'h00, exp[i]});
        end
    endtask

    initial begin
        logic [7:0] held;
        logic       stalled;
        int         n;

        rst = 1'b1; rdata_i = 16'h0; rw_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        tick();
        // A read strobe during reset must be ignored.
        rdata_i = 16'hDEAD; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        chk("rst_valid_o", valid_o, 0);
        chk("rst_data_o", data_o, 16'h00);
        chk("rst_overflow_o", overflow_o, 0);
        rst = 1'b0;
        repeat (4) tick();
        chk("rst_ignored_valid", valid_o, 0);
        chk("rst_ignored_bytes", 16'(q.size()), 0);

        // Latency: 'M' appears after the second edge following the read strobe.
        rdata_i = 16'hBEEF; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        chk("lat_edge1_valid", valid_o, 0);
        tick();
        chk("lat_edge2_valid", valid_o, 1);
        chk("lat_edge2_data", data_o, 16'h4D);
        expect_frame("beef", 8'h42, 8'h45, 8'h45, 8'h46);
        repeat (3) tick();
        chk("beef_idle", valid_o, 0);

        // Write responses produce nothing.
        q.delete();
        rdata_i = 16'h1234; rw_i = 1'b1; valid_i = 1'b1;
        tick();
        valid_i = 1'b0; rw_i = 1'b0;
        repeat (15) tick();
        chk("write_no_bytes", 16'(q.size()), 0);
        chk("write_no_valid", valid_o, 0);
        push_read(16'h09A0);
        expect_frame("09a0", 8'h30, 8'h39, 8'h41, 8'h30);

        // ready_i toggling: bytes must hold while stalled.
        q.delete();
        ready_i = 1'b0;
        push_read(16'hC0DE);
        n = 0;
        while (q.size() < FLEN && n < 60) begin
            ready_i = ~ready_i;
            stalled = valid_o && !ready_i;
            held    = data_o;
            tick();
            if (stalled) chk("stall_hold", data_o, held);
            n++;
        end
        ready_i = 1'b1;
        expect_frame("c0de", 8'h43, 8'h30, 8'h44, 8'h45);
        repeat (3) tick();

        // Overflow: one in flight plus DEPTH queued, the sixth read is dropped.
        q.delete();
        ready_i = 1'b0;
        ovf_cnt = 0;
        for (int i = 1; i <= 5; i++) begin
            push_read(16'(i));
            chk("ovf_no_pulse_early", overflow_o, 0);
        end
        push_read(16'h0006);
        chk("ovf_pulse", overflow_o, 1);
        tick();
        chk("ovf_pulse_end", overflow_o, 0);
        chk("ovf_count", 16'(ovf_cnt), 1);
        ready_i = 1'b1;
        for (int i = 1; i <= 5; i++)
            expect_frame($sformatf("ovf_f%0d", i), 8'h30, 8'h30, 8'h30, 8'h30 + 8'(i));
        repeat (20) tick();
        chk("ovf_no_sixth", 16'(q.size()), 0);
        chk("ovf_count_final", 16'(ovf_cnt), 1);

        // Reset mid-frame abandons the frame and the queue.
        q.delete();
        ready_i = 1'b0;
        push_read(16'hFACE);
        push_read(16'h1111);
        push_read(16'h2222);
        ready_i = 1'b1;
        tick();
        tick();
        rst = 1'b1; ready_i = 1'b0;
        tick();
        rst = 1'b0;
        chk("rst_mid_valid", valid_o, 0);
        chk("rst_mid_count", 16'(q.size()), 2);
        chk("rst_mid_b0", {8'h00, q[0]}, 16'h4D);
        chk("rst_mid_b1", {8'h00, q[1]}, 16'h46);
        ready_i = 1'b1;
        repeat (20) tick();
        chk("rst_mid_no_more", 16'(q.size()), 2);
        q.delete();
        push_read(16'h0042);
        expect_frame("0042", 8'h30, 8'h30, 8'h34, 8'h32);
        repeat (3) tick();

        // Full FIFO, push coincides with LF accept.
        q.delete();
        ready_i = 1'b0;
        ovf_cnt = 0;
        for (int i = 0; i <= 4; i++) push_read(16'h1000 + 16'(i));
        ready_i = 1'b1;
        repeat (FLEN - 1) tick();
        chk("full_lf_data", data_o, 16'h0A);
        rdata_i = 16'h1005; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        chk("full_lf_no_ovf", overflow_o, 0);
        chk("full_lf_nogap_valid", valid_o, 1);
        chk("full_lf_nogap_data", data_o, 16'h4D);
        for (int i = 0; i <= 5; i++)
            expect_frame($sformatf("full_f%0d", i), 8'h31, 8'h30, 8'h30, 8'h30 + 8'(i));
        repeat (10) tick();
        chk("full_no_ovf_total", 16'(ovf_cnt), 0);
        chk("full_drained", 16'(q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
